// File: rtl/mdu_sequencer_pkg.sv
// Shared MDU op codes, default latencies and sequencer state type.
// Imported by the sequencer and its arithmetic block.
package mdu_sequencer_pkg;

  localparam logic [2:0] MDU_NONE  = 3'd0;
  localparam logic [2:0] MDU_MULT  = 3'd1;
  localparam logic [2:0] MDU_MULTU = 3'd2;
  localparam logic [2:0] MDU_DIV   = 3'd3;
  localparam logic [2:0] MDU_DIVU  = 3'd4;
  localparam logic [2:0] MDU_MTHI  = 3'd5;
  localparam logic [2:0] MDU_MTLO  = 3'd6;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } mdu_state_e;

  function automatic logic is_md(input logic [2:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU) ||
           (op == MDU_DIV)  || (op == MDU_DIVU);
  endfunction

  function automatic logic is_mul(input logic [2:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU);
  endfunction

endpackage

// File: rtl/mdu_sequencer_arith.sv
// Combinational MDU datapath: latched op/operands to {hi,lo}.
// Flags divide-by-zero so the sequencer can suppress the commit.
module mdu_arith
  import mdu_sequencer_pkg::*;
(
  input  logic [2:0]  i_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [63:0] o_res,
  output logic        o_dz
);

  logic        w_bz;
  logic [31:0] w_b;
  logic signed [63:0] w_sa;
  logic signed [63:0] w_sb;

  // Divisor forced to 1 on zero so no X reaches the result mux.
  assign w_bz = (i_b == 32'd0);
  assign w_b  = w_bz ? 32'd1 : i_b;
  assign w_sa = {{32{i_a[31]}}, i_a};
  assign w_sb = {{32{i_b[31]}}, i_b};

  always_comb begin
    o_res = '0;
    o_dz  = 1'b0;
    case (i_op)
      MDU_MULT:  o_res = w_sa * w_sb;
      MDU_MULTU: o_res = {32'd0, i_a} * {32'd0, i_b};
      MDU_DIV: begin
        o_res = {$signed(i_a) % $signed(w_b),
                 $signed(i_a) / $signed(w_b)};
        o_dz  = w_bz;
      end
      MDU_DIVU: begin
        o_res = {i_a % w_b, i_a / w_b};
        o_dz  = w_bz;
      end
      default: o_res = '0;
    endcase
  end

endmodule

// File: rtl/mdu_sequencer.sv
// Multi-cycle MDU sequencer: owns HI/LO, models fixed latency,
// and raises busy for the D-stage stall logic.
module mdu_sequencer
  import mdu_sequencer_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic [2:0]  i_op,
  input  logic [31:0] i_rs_val,
  input  logic [31:0] i_rt_val,
  input  logic        i_req,
  output logic        o_busy,
  output logic [31:0] o_hi,
  output logic [31:0] o_lo
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ?
                        MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  mdu_state_e  r_state, w_nstate;
  logic [CW-1:0] r_cnt, w_ncnt;
  logic [2:0]  r_op;
  logic [31:0] r_a, r_b;
  logic [31:0] r_hi, r_lo, w_nhi, w_nlo;
  logic        w_accept, w_latch, w_dz;
  logic [63:0] w_res;

  mdu_arith u_arith (
    .i_op  (r_op),
    .i_a   (r_a),
    .i_b   (r_b),
    .o_res (w_res),
    .o_dz  (w_dz)
  );

  assign w_accept = i_start & ~i_req &
                    (i_op != MDU_NONE) &
                    (r_state == ST_IDLE);

  always_comb begin
    w_nstate = r_state;
    w_ncnt   = r_cnt;
    w_nhi    = r_hi;
    w_nlo    = r_lo;
    w_latch  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (is_md(i_op)) begin
            w_latch  = 1'b1;
            w_nstate = ST_RUN;
            w_ncnt   = is_mul(i_op) ? CW'(MULT_CYCLES - 1)
                                    : CW'(DIV_CYCLES - 1);
          end else if (i_op == MDU_MTHI) begin
            w_nhi = i_rs_val;
          end else if (i_op == MDU_MTLO) begin
            w_nlo = i_rs_val;
          end
        end
      end
      ST_RUN: begin
        if (r_cnt == '0) begin
          w_nstate = ST_IDLE;
          if (!w_dz) begin
            w_nhi = w_res[63:32];
            w_nlo = w_res[31:0];
          end
        end else begin
          w_ncnt = r_cnt - CW'(1);
        end
      end
      default: w_nstate = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_op    <= MDU_NONE;
      r_a     <= '0;
      r_b     <= '0;
    end else begin
      r_state <= w_nstate;
      r_cnt   <= w_ncnt;
      r_hi    <= w_nhi;
      r_lo    <= w_nlo;
      if (w_latch) begin
        r_op <= i_op;
        r_a  <= i_rs_val;
        r_b  <= i_rt_val;
      end
    end
  end

  // Issue-cycle term lets the stall unit see occupancy before RUN.
  assign o_busy = (i_start & is_md(i_op) & ~i_req) |
                  (r_state == ST_RUN);
  assign o_hi   = r_hi;
  assign o_lo   = r_lo;

endmodule

// File: doc/mdu_sequencer.md
# mdu_sequencer

Multi-cycle sequencer for the E-stage multiply/divide unit of the pipelined MIPS core. It accepts one HI/LO operation per start pulse and models the fixed multiply/divide latency with a counter-driven state machine. It owns the HI/LO registers and drives the `busy` flag that the stall unit consumes to hold mfhi/mflo/mthi/mtlo/mult/div in D. It also supports cancelling a start when an exception or interrupt is taken.

## Interface
Parameters:
- `MULT_CYCLES`, 5, run length for mult/multu (≥1)
- `DIV_CYCLES`, 10, run length for div/divu (≥1)

Ports:
- `clk`  in  1  single clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high; clears all state
- `start`  in  1  E-stage instruction is an MDU op this cycle
- `op`  in  3  operation code, `MDU_*` from const package
- `rs_val`  in  32  forwarded rs operand
- `rt_val`  in  32  forwarded rt operand
- `req`  in  1  exception/interrupt taken this cycle; cancels a start
- `busy`  out  1  MDU occupied; stall source for D-stage HI/LO ops
- `hi`  out  32  HI register
- `lo`  out  32  LO register

## Operation
- Op codes:
  - `MDU_NONE`=0
  - `MDU_MULT`=1
  - `MDU_MULTU`=2
  - `MDU_DIV`=3
  - `MDU_DIVU`=4
  - `MDU_MTHI`=5
  - `MDU_MTLO`=6
- A start is accepted when `start & ~req & op!=MDU_NONE` and the state is IDLE.
- States:
  - IDLE
    - Accepted mult/multu/div/divu: latch op, rs_val, rt_val. Load `cnt` = `MULT_CYCLES-1` or `DIV_CYCLES-1`. Go to RUN.
    - Accepted MTHI/MTLO: write `hi`/`lo` at that edge and stay IDLE.
  - RUN
    - `cnt` decrements each cycle.
    - When `cnt`==0: commit the result to HI/LO and go to IDLE.
- Arithmetic:
  - mult: 64-bit signed product; HI = [63:32], LO = [31:0].
  - multu: as mult, unsigned.
  - div: LO = signed quotient truncated toward zero, HI = remainder with the dividend's sign.
  - divu: as div, unsigned.
  - Results are computed from the latched operands, never the live inputs.
- Divide by zero: run full `DIV_CYCLES`; HI/LO unchanged at commit.
- `busy` = (`start` & `op` is mult/multu/div/divu & ~`req`) | (state==RUN). The first term is combinational so the stall unit sees occupancy in the issue cycle.
- A start during RUN is ignored. The stall unit guarantees this never happens legally. The bench checks that HI/LO and `cnt` are undisturbed.
- `req` affects only new starts. A running op always completes and commits, matching MARS, where the instruction has already retired.
- `reset` in any state: IDLE, `cnt`=0, `hi`=`lo`=0, `busy`=0 except for its combinational start term. Reset has priority over `start` in the same cycle: nothing is accepted.

## Timing
- Start at edge t for mult (N=`MULT_CYCLES`):
  - `busy` is high in the issue cycle and for N cycles after it, N+1 cycles total.
  - HI/LO take the new value at edge t+N.
  - `busy` is low in the cycle after edge t+N.
- MTHI/MTLO: written at the issue edge; visible the next cycle; `busy` never asserted.
- A new op can be accepted in the first cycle after commit (back-to-back, no idle gap).
- `hi`/`lo` are direct register outputs, with no combinational path from inputs.

## Structure
- `MDU_*` op codes, `MULT_CYCLES` and `DIV_CYCLES` defaults go in shared `const.v` next to the existing opcode constants. The decoder emits `op` using them.
- Optional combinational sub-module `mdu_arith` (latched op and operands → 64-bit {hi,lo} result plus div-by-zero flag). It keeps the FSM file free of arithmetic.
- `busy` connects to the stall unit's `E_MDU_busy`.

## Test plan
- mult `rs`=0xFFFFFFFE (−2), `rt`=3 → `busy` high 6 cycles; then `hi`=0xFFFFFFFF, `lo`=0xFFFFFFFA.
- multu 0xFFFFFFFF×2 → `hi`=0x00000001, `lo`=0xFFFFFFFE after 5 RUN cycles. Then immediately div −7/2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF after 10 RUN cycles, with no gap.
- divu 7/0 with HI/LO preloaded to 0x11111111/0x22222222 via MTHI/MTLO → `busy` high 11 cycles; HI/LO unchanged.
- mult 3×4 with `req`=1 in the issue cycle → `busy` never high; HI/LO unchanged. Then `req` asserted mid-RUN of a second mult → it still commits `lo`=12.
- `start` of a div during RUN of mult 5×6 → result `lo`=30, `hi`=0; the div is ignored and `busy` drops on schedule.
- `reset` in RUN cycle 3 of mult → next cycle: IDLE, `hi`=`lo`=0, `busy`=0; no late commit.
